// File: rtl/carrier_nco_pkg.sv
// carrier_nco shared types: register address map, CTRL layout, helpers.
// Used by the carrier NCO top, its bus interface and dither LFSR.
package carrier_nco_pkg;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int PW = 12;

  // Register window: 16 bytes at 0x100.
  localparam logic [AW-1:0] CARRIERNCOSPACE = 12'h100;
  localparam logic [AW-1:0] CARRIERNCOMASK  = 12'hFF0;
  localparam logic [3:0]    CENTER_OFS      = 4'h0;
  localparam logic [3:0]    CTRL_OFS        = 4'h4;

  localparam logic [15:0]   LFSR_SEED       = 16'hACE1;

  typedef struct packed {
    logic hold;
    logic invert;
    logic freeze;
  } ctrl_t;

  function automatic logic inSpace(
    input logic [AW-1:0] a
  );
    return (a & CARRIERNCOMASK) == CARRIERNCOSPACE;
  endfunction

  function automatic logic [DW-1:0] byteMerge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] d,
    input logic [3:0]    be
  );
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/carrier_nco_if.sv
// carrier_nco register bus: byte strobes wr0..wr3, addr, din, dout.
// master drives the bus, slave (the NCO) returns dout.
interface carrier_nco_if;
  import carrier_nco_pkg::*;

  logic          wr0;
  logic          wr1;
  logic          wr2;
  logic          wr3;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;

  modport master (
    output wr0, wr1, wr2, wr3,
    output addr, din,
    input  dout
  );

  modport slave (
    input  wr0, wr1, wr2, wr3,
    input  addr, din,
    output dout
  );

endinterface

// File: rtl/carrier_nco_lfsr.sv
// ncoDitherLfsr: 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1), seed 0xACE1.
// Ports: clk, reset, en_i (advance), lfsr_o (state). Built with NCO_DITHER_EN.
`ifdef NCO_DITHER_EN
module ncoDitherLfsr
  import carrier_nco_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13]
            ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/carrier_nco.sv
// carrier_nco: carrier NCO with CENTER/CTRL registers and loop offset input.
// Ports: clk, reset, clkEn, bus, carrierFreqOffset/En, carrierLock, ncoPhase/En. Dither: NCO_DITHER_EN.
module carrier_nco
  import carrier_nco_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clkEn,
  carrier_nco_if.slave  bus,
  input  logic [DW-1:0] carrierFreqOffset,
  input  logic          carrierFreqEn,
  input  logic          carrierLock,
  output logic [PW-1:0] ncoPhase,
  output logic          ncoPhaseEn
);

  logic [DW-1:0] center_q, center_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] offset_q, offset_d;
  logic [DW-1:0] freqWord_q, freqWord_d;
  logic [DW-1:0] phaseAcc_q, phaseAcc_d;
  logic [PW-1:0] ncoPhase_q, ncoPhase_d;
  logic          ncoPhaseEn_q;

  logic          selCenter;
  logic          selCtrl;
  logic [3:0]    be;
  logic          phaseClr;
  logic          holdOff;
  logic [PW-1:0] dispPhase;

  assign be = {bus.wr3, bus.wr2, bus.wr1, bus.wr0};
  assign selCenter = inSpace(bus.addr)
                  && bus.addr[3:0] == CENTER_OFS;
  assign selCtrl   = inSpace(bus.addr)
                  && bus.addr[3:0] == CTRL_OFS;

  // phaseClear is a strobe only; never stored in CTRL.
  assign phaseClr = selCtrl & bus.wr0 & bus.din[3];

  assign holdOff = ctrl_q.freeze
                 | (ctrl_q.hold & ~carrierLock);

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr;
  logic [19:0] dithSum;

  ncoDitherLfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (clkEn),
    .lfsr_o (lfsr)
  );

  // Dither lands on bits 19:12; carry may ripple into the output bits.
  assign dithSum   = phaseAcc_q[31:12] + {12'b0, lfsr[7:0]};
  assign dispPhase = dithSum[19:8];
`else
  assign dispPhase = phaseAcc_q[31:20];
`endif

  always_comb begin
    center_d = center_q;
    if (selCenter)
      center_d = byteMerge(center_q, bus.din, be);

    ctrl_d = ctrl_q;
    if (selCtrl && bus.wr0)
      ctrl_d = bus.din[2:0];

    offset_d = offset_q;
    if (carrierFreqEn && !holdOff)
      offset_d = ctrl_q.invert
               ? ~carrierFreqOffset + 32'd1
               : carrierFreqOffset;

    freqWord_d = center_q + offset_q;

    // Clear beats a coincident step.
    phaseAcc_d = phaseAcc_q;
    if (phaseClr)   phaseAcc_d = '0;
    else if (clkEn) phaseAcc_d = phaseAcc_q + freqWord_q;

    ncoPhase_d = ncoPhase_q;
    if (clkEn) ncoPhase_d = dispPhase;
  end

  always_comb begin
    bus.dout = '0;
    if (selCenter)    bus.dout = center_q;
    else if (selCtrl) bus.dout = {29'b0, ctrl_q};
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      center_q     <= '0;
      ctrl_q       <= '0;
      offset_q     <= '0;
      freqWord_q   <= '0;
      phaseAcc_q   <= '0;
      ncoPhase_q   <= '0;
      ncoPhaseEn_q <= 1'b0;
    end else begin
      center_q     <= center_d;
      ctrl_q       <= ctrl_d;
      offset_q     <= offset_d;
      freqWord_q   <= freqWord_d;
      phaseAcc_q   <= phaseAcc_d;
      ncoPhase_q   <= ncoPhase_d;
      ncoPhaseEn_q <= clkEn;
    end

  assign ncoPhase   = ncoPhase_q;
  assign ncoPhaseEn = ncoPhaseEn_q;

endmodule

// File: tb/tb_carrier_nco.sv
// tb_carrier_nco: directed stimulus, scoreboard on ncoPhase/ncoPhaseEn.
// Register and internal-state checks are compared inline.
module tb_carrier_nco;
  import carrier_nco_pkg::*;

  localparam logic [11:0] CENTER_A = 12'h100;
  localparam logic [11:0] CTRL_A   = 12'h104;

  logic        clk = 1'b0;
  logic        reset;
  logic        clkEn;
  logic [31:0] carrierFreqOffset;
  logic        carrierFreqEn;
  logic        carrierLock;
  logic [11:0] ncoPhase;
  logic        ncoPhaseEn;

  int checks   = 0;
  int failures = 0;
  logic [11:0] expQ[$];

  carrier_nco_if bus();

  carrier_nco dut (
    .clk               (clk),
    .reset             (reset),
    .clkEn             (clkEn),
    .bus               (bus),
    .carrierFreqOffset (carrierFreqOffset),
    .carrierFreqEn     (carrierFreqEn),
    .carrierLock       (carrierLock),
    .ncoPhase          (ncoPhase),
    .ncoPhaseEn        (ncoPhaseEn)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (ncoPhaseEn === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ncoPhase actual=%h required=none",
                 ncoPhase);
      end else begin
        e = expQ.pop_front();
        check("ncoPhase", {20'b0, ncoPhase}, {20'b0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [11:0] a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    tick();
    bus.addr = a;
    bus.din  = d;
    {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = s;
    tick();
    {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = 4'b0;
    tick();
  endtask

  task automatic rd(
    input string       name,
    input logic [11:0] a,
    input logic [31:0] exp
  );
    bus.addr = a;
    #1;
    check(name, bus.dout, exp);
  endtask

  task automatic freq(input logic [31:0] v);
    tick();
    carrierFreqOffset = v;
    carrierFreqEn     = 1'b1;
    tick();
    carrierFreqEn     = 1'b0;
  endtask

  task automatic steps(input int n);
    clkEn = 1'b1;
    repeat (n) tick();
    clkEn = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && expQ.size() != 0; i++)
      tick();
    check(name, 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    reset = 1'b1;
    clkEn = 1'b0;
    carrierFreqOffset = '0;
    carrierFreqEn = 1'b0;
    carrierLock = 1'b1;
    bus.addr = '0;
    bus.din  = '0;
    {bus.wr3, bus.wr2, bus.wr1, bus.wr0} = 4'b0;
    #12;
    check("rst_ncoPhase", {20'b0, ncoPhase}, 32'd0);
    check("rst_ncoPhaseEn", {31'b0, ncoPhaseEn}, 32'd0);
    rd("rst_center", CENTER_A, 32'd0);
    rd("rst_ctrl", CTRL_A, 32'd0);
    reset = 1'b0;

    // Free-running at 1/16 cycle per step.
    wr(CENTER_A, 32'h1000_0000, 4'hF);
    rd("center_rb", CENTER_A, 32'h1000_0000);
    rd("out_of_space", 12'h200, 32'd0);
    rd("unmapped_ofs", 12'h108, 32'd0);
    for (int i = 0; i < 17; i++) begin
      logic [31:0] v;
      v = i * 32'h100;
      expQ.push_back(v[11:0]);
    end
    steps(17);
    drain("drain_s1");

    // Offset cancels the center: phase freezes.
    freq(32'hF000_0000);
    check("offset_f000", dut.offset_q, 32'hF000_0000);
    tick();
    check("freqWord_zero", dut.freqWord_q, 32'd0);
    repeat (4) expQ.push_back(12'h100);
    steps(4);
    drain("drain_s2");

    // Inverted offset.
    wr(CTRL_A, 32'h2, 4'h1);
    rd("ctrl_inv_rb", CTRL_A, 32'h2);
    freq(32'h0000_0100);
    check("offset_inv", dut.offset_q, 32'hFFFF_FF00);
    tick();
    check("freqWord_inv", dut.freqWord_q, 32'h0FFF_FF00);
    expQ.push_back(12'h100);
    expQ.push_back(12'h1FF);
    expQ.push_back(12'h2FF);
    steps(3);
    drain("drain_s3");

    // Hold on unlock, then release.
    wr(CTRL_A, 32'h4, 4'h1);
    carrierLock = 1'b0;
    freq(32'h0000_1234);
    check("hold_unlock_a", dut.offset_q, 32'hFFFF_FF00);
    freq(32'h0000_5678);
    check("hold_unlock_b", dut.offset_q, 32'hFFFF_FF00);
    carrierLock = 1'b1;
    freq(32'h0000_1234);
    check("lock_load", dut.offset_q, 32'h0000_1234);
    tick();
    check("freqWord_lock", dut.freqWord_q, 32'h1000_1234);

    // Freeze.
    wr(CTRL_A, 32'h1, 4'h1);
    rd("ctrl_frz_rb", CTRL_A, 32'h1);
    freq(32'h0000_0055);
    check("freeze_hold", dut.offset_q, 32'h0000_1234);

    // Byte-strobed CENTER writes.
    wr(CENTER_A, 32'h2000_0000, 4'b1000);
    rd("center_b3", CENTER_A, 32'h2000_0000);
    wr(CENTER_A, 32'hFFFF_FFAB, 4'b0001);
    rd("center_b0", CENTER_A, 32'h2000_00AB);
    check("freqWord_part", dut.freqWord_q, 32'h2000_12DF);

    wr(CTRL_A, 32'h0, 4'h1);
    freq(32'h0);
    check("offset_zero", dut.offset_q, 32'h0);
    wr(CENTER_A, 32'h1000_0000, 4'hF);
    check("freqWord_restore", dut.freqWord_q, 32'h1000_0000);

    // phaseClear coinciding with clkEn.
    tick();
    bus.addr = CTRL_A;
    bus.din  = 32'h8;
    bus.wr0  = 1'b1;
    clkEn    = 1'b1;
    expQ.push_back(12'h3FF);
    expQ.push_back(12'h000);
    expQ.push_back(12'h100);
    tick();
    bus.wr0 = 1'b0;
    check("phaseAcc_clear", dut.phaseAcc_q, 32'd0);
    tick();
    tick();
    clkEn = 1'b0;
    drain("drain_s5");
    rd("ctrl_clear_rb", CTRL_A, 32'h0);

    // Reset mid-run, between edges.
    expQ.push_back(12'h200);
    expQ.push_back(12'h300);
    tick();
    clkEn = 1'b1;
    tick();
    tick();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ncoPhase", {20'b0, ncoPhase}, 32'd0);
    check("mid_rst_ncoPhaseEn", {31'b0, ncoPhaseEn}, 32'd0);
    check("mid_rst_phaseAcc", dut.phaseAcc_q, 32'd0);
    check("mid_rst_freqWord", dut.freqWord_q, 32'd0);
    rd("mid_rst_center", CENTER_A, 32'd0);
    rd("mid_rst_ctrl", CTRL_A, 32'd0);
    clkEn = 1'b0;
    reset = 1'b0;
    check("post_rst_queue", 32'(expQ.size()), 32'd0);
    expQ.delete();

    // First steps after reset start from zero.
    wr(CENTER_A, 32'h1000_0000, 4'hF);
    expQ.push_back(12'h000);
    expQ.push_back(12'h100);
    steps(2);
    drain("drain_s6");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
